// File: rtl/cpu_pkg.sv
// Shared types and encodings for the instruction sequencer and its decoder.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the instruction register into register addresses,
// ALU operation and immediate controls.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [4:0]  readReg1_o,
  output logic [4:0]  readReg2_o,
  output logic [4:0]  writeReg_o,
  output logic [3:0]  ALUOp_o,
  output logic        aluSrcImm_o,
  output logic [31:0] imm_o,
  output logic        legal_o,
  output logic        isSystem_o
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic signed [31:0] imm_s;

  assign opcode     = ir_i[6:0];
  assign funct3     = ir_i[14:12];
  assign readReg1_o = ir_i[19:15];
  assign readReg2_o = ir_i[24:20];
  assign writeReg_o = ir_i[11:7];
  assign imm_s      = {{20{ir_i[31]}}, ir_i[31:20]};
  assign imm_o      = imm_s;

  always_comb begin
    ALUOp_o     = ALU_ADD;
    aluSrcImm_o = 1'b0;
    legal_o     = 1'b0;
    isSystem_o  = 1'b0;
    case (opcode)
      OPC_OP: begin
        ALUOp_o = {ir_i[30], funct3};
        legal_o = 1'b1;
      end
      OPC_OPIMM: begin
        // Only the shift-right immediates use IR[30] to pick SRA vs SRL.
        ALUOp_o     = (funct3 == 3'b101) ? {ir_i[30], 3'b101} : {1'b0, funct3};
        aluSrcImm_o = 1'b1;
        legal_o     = 1'b1;
      end
      OPC_SYSTEM: isSystem_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM: fetches over a req/ack
// handshake, holds the instruction register and sequences the regWrite strobe.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic              imemAck,
  input  logic [31:0]       imemData,
  output logic [4:0]        readReg1,
  output logic [4:0]        readReg2,
  output logic [4:0]        writeReg,
  output logic [3:0]        ALUOp,
  output logic              aluSrcImm,
  output logic [31:0]       imm,
  output logic              regWrite,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [31:0]       instrCount
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              illegal_q, illegal_d;
  logic              dec_legal, dec_system;

  instr_decoder u_dec (
    .ir_i        (ir_q),
    .readReg1_o  (readReg1),
    .readReg2_o  (readReg2),
    .writeReg_o  (writeReg),
    .ALUOp_o     (ALUOp),
    .aluSrcImm_o (aluSrcImm),
    .imm_o       (imm),
    .legal_o     (dec_legal),
    .isSystem_o  (dec_system)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imemAck) begin
          ir_d    = imemData;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d   = S_HALT;
          illegal_d = !dec_system;
        end
      end
      S_EXECUTE: begin
        // Retirement counts even when the x0 write is suppressed.
        cnt_d   = cnt_q + 32'd1;
        pc_d    = pc_q + ADDR_W'(4);
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = RESET_PC;
          illegal_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode directly from state so an async reset kills them at once.
  assign imemReq    = (state_q == S_FETCH);
  assign imemAddr   = pc_q;
  assign regWrite   = (state_q == S_EXECUTE) && (writeReg != 5'd0);
  assign busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                      (state_q == S_EXECUTE);
  assign halted     = (state_q == S_HALT);
  assign illegal    = illegal_q;
  assign instrCount = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table of instructions with expected
// decode results, plus hand sequences for halts, restarts and async reset.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, imemAck;
  logic [31:0] imemData;
  logic        imemReq, aluSrcImm, regWrite, busy, halted, illegal;
  logic [31:0] imemAddr, imm, instrCount;
  logic [4:0]  readReg1, readReg2, writeReg;
  logic [3:0]  ALUOp;

  instr_sequencer #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .readReg1(readReg1), .readReg2(readReg2), .writeReg(writeReg),
    .ALUOp(ALUOp), .aluSrcImm(aluSrcImm), .imm(imm), .regWrite(regWrite),
    .busy(busy), .halted(halted), .illegal(illegal), .instrCount(instrCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          delay;
    logic [4:0]  rr1, rr2, wr;
    logic [3:0]  alu;
    logic        src;
    logic [31:0] imm;
    logic        rw;
  } vec_t;

  vec_t        vecs[8];
  vec_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc, exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assumes the DUT is in FETCH; drives the ack after v.delay idle cycles.
  task automatic run_vec(input vec_t v);
    vec_t e;
    chk("fetch_req", imemReq, 1);
    chk("fetch_addr", imemAddr, exp_pc);
    for (int d = 0; d < v.delay; d++) begin
      imemAck  = 1'b0;
      imemData = 32'hFFFF_FFFF;
      step();
      chk("wait_req", imemReq, 1);
      chk("wait_addr", imemAddr, exp_pc);
    end
    imemAck  = 1'b1;
    imemData = v.instr;
    sb_q.push_back(v);
    step();
    imemAck  = 1'b0;
    imemData = 32'hFFFF_FFFF;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    chk("dec_rr1", readReg1, e.rr1);
    chk("dec_rr2", readReg2, e.rr2);
    chk("dec_wr", writeReg, e.wr);
    chk("dec_alu", ALUOp, e.alu);
    chk("dec_src", aluSrcImm, e.src);
    chk("dec_imm", imm, e.imm);
    chk("dec_req", imemReq, 0);
    chk("dec_rw", regWrite, 0);
    chk("dec_busy", busy, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ex_rw", regWrite, e.rw);
    chk("ex_alu_stable", ALUOp, e.alu);
    chk("ex_imm_stable", imm, e.imm);
    chk("ex_cnt", instrCount, exp_cnt);
    chk("ex_busy", busy, 1);
    step();
    exp_cnt = exp_cnt + 1;
    exp_pc  = exp_pc + 4;
    chk("post_rw", regWrite, 0);
    chk("post_cnt", instrCount, exp_cnt);
    chk("post_addr", imemAddr, exp_pc);
    chk("post_req", imemReq, 1);
  endtask

  task automatic run_halt(input logic [31:0] instr, input logic exp_ill);
    chk("h_fetch_req", imemReq, 1);
    imemAck  = 1'b1;
    imemData = instr;
    step();
    imemAck  = 1'b0;
    chk("h_dec_halted", halted, 0);
    chk("h_dec_busy", busy, 1);
    step();
    chk("h_halted", halted, 1);
    chk("h_illegal", illegal, exp_ill);
    chk("h_busy", busy, 0);
    chk("h_req", imemReq, 0);
    step();
    step();
    chk("h_pc_frozen", imemAddr, exp_pc);
    chk("h_cnt_frozen", instrCount, exp_cnt);
    chk("h_still_halted", halted, 1);
    chk("h_ill_sticky", illegal, exp_ill);
    start = 1'b1;
    step();
    start  = 1'b0;
    exp_pc = 32'h0;
    chk("rs_req", imemReq, 1);
    chk("rs_addr", imemAddr, 32'h0);
    chk("rs_illegal", illegal, 0);
    chk("rs_halted", halted, 0);
    chk("rs_cnt", instrCount, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h002081B3, 0, 5'd1,  5'd2,  5'd3,  4'b0000, 1'b0, 32'h0000_0002, 1'b1};
    vecs[1] = '{32'h40208233, 0, 5'd1,  5'd2,  5'd4,  4'b1000, 1'b0, 32'h0000_0402, 1'b1};
    vecs[2] = '{32'h4030D293, 1, 5'd1,  5'd3,  5'd5,  4'b1101, 1'b1, 32'h0000_0403, 1'b1};
    vecs[3] = '{32'hFFF00013, 0, 5'd0,  5'd31, 5'd0,  4'b0000, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{32'h0F017313, 2, 5'd2,  5'd16, 5'd6,  4'b0111, 1'b1, 32'h0000_00F0, 1'b1};
    vecs[5] = '{32'h00445493, 5, 5'd8,  5'd4,  5'd9,  4'b0101, 1'b1, 32'h0000_0004, 1'b1};
    vecs[6] = '{32'h00C5A533, 0, 5'd11, 5'd12, 5'd10, 4'b0010, 1'b0, 32'h0000_000C, 1'b1};
    vecs[7] = '{32'h40010093, 0, 5'd2,  5'd0,  5'd1,  4'b0000, 1'b1, 32'h0000_0400, 1'b1};

    rst = 1'b1; start = 1'b0; imemAck = 1'b0; imemData = 32'h0;
    exp_pc = 32'h0; exp_cnt = 32'h0;
    step();
    step();
    chk("rst_req", imemReq, 0);
    chk("rst_addr", imemAddr, 32'h0);
    chk("rst_rw", regWrite, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_cnt", instrCount, 0);
    chk("rst_alu", ALUOp, 0);
    chk("rst_imm", imm, 0);
    chk("rst_src", aluSrcImm, 0);
    rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);
    chk("idle_req", imemReq, 0);
    start = 1'b1;
    step();
    start = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    run_halt(32'h0000_0073, 1'b0);
    run_vec(vecs[0]);
    run_halt(32'h0000_007F, 1'b1);

    // Async reset mid-FETCH with an ack in flight and start asserted.
    imemAck  = 1'b1;
    imemData = 32'h002081B3;
    start    = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rf_req", imemReq, 0);
    chk("rf_busy", busy, 0);
    chk("rf_rw", regWrite, 0);
    chk("rf_cnt", instrCount, 0);
    chk("rf_addr", imemAddr, 32'h0);
    step();
    imemAck = 1'b0;
    start   = 1'b0;
    rst     = 1'b0;
    exp_cnt = 32'h0;
    exp_pc  = 32'h0;
    sb_q.delete();
    step();
    chk("rf_idle_busy", busy, 0);
    chk("rf_ack_dropped", writeReg, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    run_vec(vecs[1]);
    // Async reset mid-EXECUTE.
    imemAck  = 1'b1;
    imemData = 32'h002081B3;
    step();
    imemAck = 1'b0;
    step();
    chk("re_rw_before", regWrite, 1);
    #2 rst = 1'b1;
    #1;
    chk("re_rw", regWrite, 0);
    chk("re_req", imemReq, 0);
    chk("re_busy", busy, 0);
    chk("re_cnt", instrCount, 0);
    chk("re_addr", imemAddr, 32'h0);
    step();
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
